// File: rtl/popcount21_kgen.sv
// Enumerates every 21-bit vector with exactly k ones, in ascending order,
// through a valid/ready stream. Successors come from Gosper's rule.
module popcount21_kgen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  k_in,
    input  logic        vec_ready,
    output logic        vec_valid,
    output logic [20:0] vec_out,
    output logic [18:0] vec_idx,
    output logic        busy,
    output logic        done,
    output logic [18:0] total_out,
    output logic        err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic        k_zero;
    logic [21:0] x;
    logic [21:0] c;
    logic [21:0] r;
    logic [21:0] spread;
    logic [4:0]  low_pos;
    logic [20:0] next_vec;
    logic [20:0] init_vec;
    logic        last;

    // Gosper successor; the divide by c is a shift by the position of the lowest one.
    always_comb begin
        x       = {1'b0, vec_out};
        c       = x & (~x + 22'd1);
        r       = x + c;
        low_pos = 5'd0;
        for (int i = 20; i >= 0; i--) begin
            if (vec_out[i]) low_pos = 5'(i);
        end
        spread   = ((r ^ x) >> 2) >> low_pos;
        next_vec = 21'(r | spread);
        last     = r[21] | k_zero;
        init_vec = 21'((22'd1 << k_in) - 22'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_zero    <= 1'b0;
            vec_valid <= 1'b0;
            vec_out   <= '0;
            vec_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            total_out <= '0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k_in <= 5'd21) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            vec_valid <= 1'b1;
                            vec_out   <= init_vec;
                            vec_idx   <= '0;
                            k_zero    <= (k_in == 5'd0);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (vec_valid && vec_ready) begin
                        if (last) begin
                            state     <= IDLE;
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            total_out <= vec_idx + 19'd1;
                        end else begin
                            vec_out <= next_vec;
                            vec_idx <= vec_idx + 19'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount21_kgen.sv
// Directed bench for popcount21_kgen: walks k=2,0,21,22,20 and a reset abort
// at k=3, checking each vector against an independent popcount/order model.
module tb_popcount21_kgen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  k_in;
    logic        vec_ready;
    logic        vec_valid;
    logic [20:0] vec_out;
    logic [18:0] vec_idx;
    logic        busy;
    logic        done;
    logic [18:0] total_out;
    logic        err;

    int          checks;
    int          errors;
    int          n_xfer;
    bit          saw_done;
    logic [20:0] got_first;
    logic [20:0] got_second;
    logic [20:0] got_third;
    logic [20:0] got_last;

    popcount21_kgen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_in      (k_in),
        .vec_ready (vec_ready),
        .vec_valid (vec_valid),
        .vec_out   (vec_out),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .total_out (total_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_vec_valid"}, 32'(vec_valid), 32'd0);
        checkOutput({tag, "_vec_out"},   32'(vec_out),   32'd0);
        checkOutput({tag, "_vec_idx"},   32'(vec_idx),   32'd0);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_total_out"}, 32'(total_out), 32'd0);
        checkOutput({tag, "_err"},       32'(err),       32'd0);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the start edge.
    task automatic applyStimulus(input int k);
        start = 1'b1;
        k_in  = 5'(k);
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy",  32'(busy),      32'd1);
        checkOutput("start_valid", 32'(vec_valid), 32'd1);
        checkOutput("start_vec",   32'(vec_out),   (32'd1 << k) - 32'd1);
        checkOutput("start_idx",   32'(vec_idx),   32'd0);
    endtask

    // Consumes the stream, checking popcount, order, index and stall stability.
    task automatic runEnum(input int k, input bit rnd, input int stop_after, input bit poke);
        logic [20:0] prev_vec;
        logic [18:0] prev_idx;
        bit          stalled;
        bit          poked;
        n_xfer   = 0;
        saw_done = 1'b0;
        stalled  = 1'b0;
        poked    = 1'b0;
        prev_vec = '0;
        prev_idx = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (done) begin
                saw_done = 1'b1;
                checkOutput("done_total", 32'(total_out), 32'(n_xfer));
                break;
            end
            if (stop_after != 0 && n_xfer == stop_after) break;
            if (vec_valid) begin
                if (stalled) begin
                    checkOutput("stall_vec", 32'(vec_out), 32'(prev_vec));
                    checkOutput("stall_idx", 32'(vec_idx), 32'(prev_idx));
                end
                vec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (vec_ready) begin
                    checkOutput("popcount", 32'($countones(vec_out)), 32'(k));
                    checkOutput("xfer_idx", 32'(vec_idx), 32'(n_xfer));
                    checkOutput("xfer_busy", 32'(busy), 32'd1);
                    if (n_xfer > 0) checkOutput("ascending", 32'(vec_out > got_last), 32'd1);
                    if (n_xfer == 0) got_first  = vec_out;
                    if (n_xfer == 1) got_second = vec_out;
                    if (n_xfer == 2) got_third  = vec_out;
                    got_last = vec_out;
                    n_xfer++;
                end
                stalled  = !vec_ready;
                prev_vec = vec_out;
                prev_idx = vec_idx;
            end
            if (poke && !poked && n_xfer == 10) begin
                start = 1'b1;
                k_in  = 5'd5;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (stop_after == 0) checkOutput("done_seen", 32'(saw_done), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        got_first = '0; got_second = '0; got_third = '0; got_last = '0;
        start     = 1'b0;
        k_in      = 5'd0;
        vec_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2);
        runEnum(2, 1'b0, 0, 1'b0);
        checkOutput("k2_count",  32'(n_xfer),     32'd210);
        checkOutput("k2_first",  32'(got_first),  32'h000003);
        checkOutput("k2_second", 32'(got_second), 32'h000005);
        checkOutput("k2_third",  32'(got_third),  32'h000006);
        checkOutput("k2_last",   32'(got_last),   32'h180000);

        // Restart in the done cycle.
        applyStimulus(0);
        runEnum(0, 1'b0, 0, 1'b0);
        checkOutput("k0_count", 32'(n_xfer),    32'd1);
        checkOutput("k0_vec",   32'(got_first), 32'h000000);

        applyStimulus(21);
        runEnum(21, 1'b0, 0, 1'b0);
        checkOutput("k21_count", 32'(n_xfer),    32'd1);
        checkOutput("k21_vec",   32'(got_first), 32'h1FFFFF);
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy",  32'(busy), 32'd0);

        start = 1'b1;
        k_in  = 5'd22;
        @(negedge clk);
        start = 1'b0;
        checkOutput("k22_err",   32'(err),       32'd1);
        checkOutput("k22_valid", 32'(vec_valid), 32'd0);
        checkOutput("k22_busy",  32'(busy),      32'd0);
        checkOutput("k22_total", 32'(total_out), 32'd1);
        @(negedge clk);
        checkOutput("k22_err_pulse", 32'(err),       32'd0);
        checkOutput("k22_valid2",    32'(vec_valid), 32'd0);

        applyStimulus(20);
        runEnum(20, 1'b1, 0, 1'b0);
        checkOutput("k20_count", 32'(n_xfer),    32'd21);
        checkOutput("k20_first", 32'(got_first), 32'h0FFFFF);
        checkOutput("k20_last",  32'(got_last),  32'h1FFFFE);

        applyStimulus(3);
        runEnum(3, 1'b0, 50, 1'b1);
        checkOutput("k3_count", 32'(n_xfer), 32'd50);
        checkOutput("k3_busy",  32'(busy),   32'd1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_busy",  32'(busy),      32'd0);
        checkOutput("post_valid", 32'(vec_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
